// File: rtl/cpu_debug_pkg.sv
// Shared opcodes, controller state codes and status-word layout for the cpu debug controller.
// Pure declarations: no logic, no latency, no flow control.
package cpu_debug_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_RESET_CPU = 3'd1,
    OP_CONTINUE  = 3'd2,
    OP_READ_REG  = 3'd3,
    OP_READ_MEM  = 3'd4,
    OP_WRITE_MEM = 3'd5,
    OP_STATUS    = 3'd6,
    OP_RSVD      = 3'd7
  } cmd_op_e;

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_CONT   = 3'd2;
  localparam logic [2:0] ST_REG    = 3'd3;
  localparam logic [2:0] ST_MEM_RD = 3'd4;
  localparam logic [2:0] ST_MEM_WR = 3'd5;
  localparam logic [2:0] ST_RSP    = 3'd6;

  localparam logic [3:0] REG_IP = 4'd8;

  localparam int STATUS_HALTED = 0;
  localparam int STATUS_WAIT   = 1;
  localparam int STATUS_RESET  = 2;

endpackage

// File: rtl/mem_port_mux.sv
// Data RAM port mux: host fields when host_grant is set, processor request otherwise.
// Purely combinational, zero latency; no backpressure (grant already implies a parked cpu).
module mem_port_mux #(
  parameter int WORD_SIZE = 18,
  parameter int ADDR_SIZE = 18
) (
  input  logic                 host_grant,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_din,
  input  logic                 cpu_mem_we,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic [WORD_SIZE-1:0] cpu_mem_din,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din
);

  // A processor write during grant is simply dropped.
  assign ram_we   = host_grant ? host_we   : cpu_mem_we;
  assign ram_addr = host_grant ? host_addr : cpu_mem_addr;
  assign ram_din  = host_grant ? host_din  : cpu_mem_din;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Host run/debug controller: sequences cpu reset, continue, debug reads and host RAM access.
// One command in flight; response held until rsp_ready, cmd_ready only while idle.
module cpu_debug_ctrl
  import cpu_debug_pkg::*;
#(
  parameter int WORD_SIZE    = 18,
  parameter int ADDR_SIZE    = 18,
  parameter int RESET_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_error,
  output logic                 halted,
  output logic                 cpu_reset,
  input  logic                 cpu_wait_for_continue,
  output logic                 cpu_continue,
  output logic                 cpu_debug_get_param,
  output logic [3:0]           cpu_debug_reg_addr,
  input  logic [WORD_SIZE-1:0] cpu_debug_data_out,
  input  logic                 cpu_mem_we,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic [WORD_SIZE-1:0] cpu_mem_din,
  output logic [WORD_SIZE-1:0] cpu_mem_dout,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 2);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 host_grant;
  logic                 rst_rsp;
  logic [WORD_SIZE-1:0] status_word;

  assign cpu_reset           = (state == ST_RST);
  assign cmd_ready           = (state == ST_IDLE);
  assign rsp_valid           = (state == ST_RSP);
  assign cpu_continue        = (state == ST_CONT);
  assign cpu_debug_get_param = (state == ST_REG);
  assign cpu_debug_reg_addr  = cpu_debug_get_param ? addr_q[3:0] : 4'd0;
  assign cpu_mem_dout        = ram_dout;

  always_comb begin
    status_word                = '0;
    status_word[STATUS_HALTED] = halted;
    status_word[STATUS_WAIT]   = cpu_wait_for_continue;
    status_word[STATUS_RESET]  = cpu_reset;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_RST;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      host_grant <= 1'b0;
      halted     <= 1'b0;
      rst_rsp    <= 1'b0;
    end else begin
      halted <= cpu_wait_for_continue & ~cpu_reset;
      case (state)
        ST_RST: begin
          if (cnt == RST_LAST) begin
            cnt     <= '0;
            rst_rsp <= 1'b0;
            state   <= rst_rsp ? ST_RSP : ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            state     <= ST_RSP;
            // Anything needing the processor parked is rejected here, before any side effect.
            case (cmd_op_e'(cmd_op))
              OP_NOP: ;
              OP_RESET_CPU: begin
                rst_rsp <= 1'b1;
                state   <= ST_RST;
              end
              OP_CONTINUE: begin
                if (halted) state <= ST_CONT;
                else rsp_error <= 1'b1;
              end
              OP_READ_REG: begin
                if (halted && cmd_addr[3:0] <= REG_IP) state <= ST_REG;
                else rsp_error <= 1'b1;
              end
              OP_READ_MEM: begin
                if (halted) begin
                  host_grant <= 1'b1;
                  state      <= ST_MEM_RD;
                end else begin
                  rsp_error <= 1'b1;
                end
              end
              OP_WRITE_MEM: begin
                if (halted) begin
                  host_grant <= 1'b1;
                  state      <= ST_MEM_WR;
                end else begin
                  rsp_error <= 1'b1;
                end
              end
              OP_STATUS: rsp_data <= status_word;
              default:   rsp_error <= 1'b1;
            endcase
          end
        end
        ST_CONT: state <= ST_RSP;
        ST_REG: begin
          if (cnt == CNT_W'(1)) begin
            cnt      <= '0;
            rsp_data <= cpu_debug_data_out;
            state    <= ST_RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MEM_RD: begin
          // First cycle presents the address, second sees the synchronous read data.
          if (cnt == CNT_W'(1)) begin
            cnt        <= '0;
            rsp_data   <= ram_dout;
            host_grant <= 1'b0;
            state      <= ST_RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MEM_WR: begin
          rsp_data   <= data_q;
          host_grant <= 1'b0;
          state      <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_RST;
      endcase
    end
  end

  mem_port_mux #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem_port_mux (
    .host_grant  (host_grant),
    .host_we     (state == ST_MEM_WR),
    .host_addr   (addr_q),
    .host_din    (data_q),
    .cpu_mem_we  (cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_din (cpu_mem_din),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din)
  );

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: processor stub, sync RAM, command-level response model.
// Directed command sequence; one negedge monitor compares outputs every cycle.
module tb_cpu_debug_ctrl;
  import cpu_debug_pkg::*;

  localparam int W       = 18;
  localparam int A       = 18;
  localparam int RC      = 2;
  localparam int RUN_LEN = 24;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_error, halted;
  logic [2:0]   cmd_op;
  logic [A-1:0] cmd_addr, cpu_mem_addr, ram_addr;
  logic [W-1:0] cmd_data, rsp_data, cpu_debug_data_out, cpu_mem_din, cpu_mem_dout;
  logic [W-1:0] ram_din, ram_dout;
  logic         cpu_reset, cpu_continue, cpu_debug_get_param, cpu_mem_we, ram_we;
  logic [3:0]   cpu_debug_reg_addr;
  logic         cpu_wait_for_continue = 1'b0;

  always #5 clock = ~clock;

  cpu_debug_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A), .RESET_CYCLES(RC)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .halted(halted), .cpu_reset(cpu_reset), .cpu_wait_for_continue(cpu_wait_for_continue),
    .cpu_continue(cpu_continue), .cpu_debug_get_param(cpu_debug_get_param),
    .cpu_debug_reg_addr(cpu_debug_reg_addr), .cpu_debug_data_out(cpu_debug_data_out),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din),
    .cpu_mem_dout(cpu_mem_dout),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Processor stub: runs RUN_LEN steps after reset or continue, then parks at wait.
  logic [W-1:0] ip = '0;
  int           run_left = RUN_LEN;

  always @(posedge clock) begin
    if (cpu_reset) begin
      run_left              <= RUN_LEN;
      cpu_wait_for_continue <= 1'b0;
      ip                    <= '0;
    end else if (cpu_wait_for_continue) begin
      if (cpu_continue) begin
        cpu_wait_for_continue <= 1'b0;
        run_left              <= RUN_LEN;
      end
    end else if (run_left == 0) begin
      cpu_wait_for_continue <= 1'b1;
    end else begin
      run_left <= run_left - 1;
      ip       <= ip + 1'b1;
    end
  end

  function automatic logic [W-1:0] reg_val(input logic [3:0] i, input logic [W-1:0] ipv);
    if (i == REG_IP) return ipv;
    if (i == 4'd1) return 18'h2AAAA;
    return 18'h15000 + W'(i);
  endfunction

  assign cpu_debug_data_out = cpu_debug_get_param ? reg_val(cpu_debug_reg_addr, ip) : 18'h3FFFF;
  assign cpu_mem_we   = ~cpu_reset & ~cpu_wait_for_continue & (ip[1:0] == 2'd1);
  assign cpu_mem_addr = 18'h100 + ip;
  assign cpu_mem_din  = ip ^ 18'h3C3C3;

  logic [W-1:0] ram     [0:1023];
  logic [W-1:0] exp_mem [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = W'(i * 7);
      exp_mem[i] = W'(i * 7);
    end
  end

  always @(posedge clock) begin
    if (ram_we) ram[ram_addr[9:0]] <= ram_din;
    ram_dout <= ram[ram_addr[9:0]];
  end

  // Model: processor writes land in memory; halted is "parked and not in reset" one cycle late.
  logic mh;
  always @(posedge clock or negedge reset) begin
    if (!reset) mh <= 1'b0;
    else        mh <= cpu_wait_for_continue & ~cpu_reset;
  end

  always @(posedge clock) begin
    if (cpu_mem_we) exp_mem[cpu_mem_addr[9:0]] = cpu_mem_din;
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_r;
  int   cont_exp = 0, cont_seen = 0, hw_exp = 0, hw_seen = 0;

  task automatic predict(input logic [2:0] op, input logic [A-1:0] addr, input logic [W-1:0] data);
    rsp_t r;
    r.data = '0;
    r.err  = 1'b0;
    case (op)
      3'd2: if (mh) cont_exp++; else r.err = 1'b1;
      3'd3: if (mh && addr[3:0] <= 4'd8) r.data = reg_val(addr[3:0], ip); else r.err = 1'b1;
      3'd4: if (mh) r.data = exp_mem[addr[9:0]]; else r.err = 1'b1;
      3'd5: begin
        if (mh) begin
          r.data = data;
          exp_mem[addr[9:0]] = data;
          hw_exp++;
        end else begin
          r.err = 1'b1;
        end
      end
      3'd6: r.data = {15'b0, 1'b0, cpu_wait_for_continue, mh};
      3'd7: r.err = 1'b1;
      default: ;
    endcase
    exp_q.push_back(r);
  endtask

  logic         prev_rv = 1'b0, prev_hs = 1'b0, prev_re = 1'b0;
  logic [W-1:0] prev_rd = '0;

  always @(negedge clock) begin
    check("cpu_mem_dout", cpu_mem_dout, ram_dout);
    check("halted", W'(halted), W'(mh));
    if (!mh) begin
      check("ram_we_pass", W'(ram_we), W'(cpu_mem_we));
      check("ram_addr_pass", ram_addr, cpu_mem_addr);
      check("ram_din_pass", ram_din, cpu_mem_din);
    end
    if (reset) begin
      if (ram_we && !cpu_mem_we) hw_seen++;
      if (cpu_continue) cont_seen++;
      if (rsp_valid && prev_rv && !prev_hs) begin
        check("rsp_data_stable", rsp_data, prev_rd);
        check("rsp_error_stable", W'(rsp_error), W'(prev_re));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", W'(rsp_valid), '0);
        end else begin
          mon_r = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_r.data);
          check("rsp_error", W'(rsp_error), W'(mon_r.err));
        end
      end
      prev_rv = rsp_valid;
      prev_hs = rsp_valid & rsp_ready;
      prev_rd = rsp_data;
      prev_re = rsp_error;
    end else begin
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end
  end

  logic [W-1:0] last_data;
  logic         last_err;

  task automatic do_cmd(input logic [2:0] op, input logic [A-1:0] addr,
                        input logic [W-1:0] data, input int hold);
    int n;
    @(negedge clock);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin n++; @(negedge clock); end
    check("cmd_ready", W'(cmd_ready), W'(1));
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    predict(op, addr, data);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (hold) @(posedge clock);
    #1 rsp_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 200) begin n++; @(negedge clock); end
    check("rsp_valid", W'(rsp_valid), W'(1));
    last_data = rsp_data;
    last_err  = rsp_error;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic count_rst(output int n);
    n = 0;
    @(negedge clock);
    while (cpu_reset && n < 50) begin n++; @(negedge clock); end
  endtask

  task automatic wait_halted();
    int n = 0;
    @(negedge clock);
    while (!halted && n < 300) begin n++; @(negedge clock); end
    check("halted_reached", W'(halted), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, mism;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cpu_reset", W'(cpu_reset), W'(1));
    check("rst_cmd_ready", W'(cmd_ready), '0);
    check("rst_rsp_valid", W'(rsp_valid), '0);
    check("rst_rsp_error", W'(rsp_error), '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_continue", W'(cpu_continue), '0);
    check("rst_get_param", W'(cpu_debug_get_param), '0);
    check("rst_reg_addr", W'(cpu_debug_reg_addr), '0);
    check("rst_ram_we", W'(ram_we), '0);
    @(posedge clock);
    #1 reset = 1'b1;
    count_rst(n);
    check("reset_cycles", W'(n), W'(RC));
    check("idle_cmd_ready", W'(cmd_ready), W'(1));

    do_cmd(3'd6, '0, '0, 0);
    check("status_running", last_data, '0);
    do_cmd(3'd4, 18'd5, '0, 0);
    check("rdmem_running_err", W'(last_err), W'(1));
    do_cmd(3'd5, 18'd7, 18'h00BAD, 0);
    do_cmd(3'd2, '0, '0, 0);

    wait_halted();
    do_cmd(3'd6, '0, '0, 0);
    check("status_parked", last_data, 18'h3);
    do_cmd(3'd3, 18'd1, '0, 0);
    check("reg_r1", last_data, 18'h2AAAA);
    check("reg_r1_err", W'(last_err), '0);
    do_cmd(3'd3, 18'd8, '0, 0);
    check("reg_ip", last_data, W'(RUN_LEN));
    do_cmd(3'd3, 18'd9, '0, 0);
    check("reg_9_err", W'(last_err), W'(1));
    do_cmd(3'd3, 18'h3000F, '0, 0);
    do_cmd(3'd3, 18'd3, '0, 3);
    do_cmd(3'd5, 18'd5, 18'h12345, 2);
    check("wrmem_echo", last_data, 18'h12345);
    do_cmd(3'd4, 18'd5, '0, 0);
    check("rdmem_5", last_data, 18'h12345);
    do_cmd(3'd4, 18'h105, '0, 1);
    do_cmd(3'd0, '0, '0, 0);
    do_cmd(3'd7, '0, '0, 0);
    check("reserved_err", W'(last_err), W'(1));

    do_cmd(3'd2, '0, '0, 0);
    check("continue_ok", W'(last_err), '0);
    do_cmd(3'd2, '0, '0, 0);
    check("continue_again_err", W'(last_err), W'(1));

    wait_halted();
    do_cmd(3'd1, '0, '0, 0);
    wait_halted();

    // Reset lands while the host owns the RAM mid read, with no consumer for the response.
    @(negedge clock);
    cmd_op = 3'd4; cmd_addr = 18'd5; cmd_valid = 1'b1;
    check("midrst_cmd_ready", W'(cmd_ready), W'(1));
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    check("host_ram_addr", ram_addr, 18'd5);
    #3 reset = 1'b0;
    #1;
    check("midrst_rsp_valid", W'(rsp_valid), '0);
    check("midrst_cpu_reset", W'(cpu_reset), W'(1));
    check("midrst_ram_addr", ram_addr, cpu_mem_addr);
    @(posedge clock);
    #1 reset = 1'b1;
    count_rst(n);
    check("reset_cycles_again", W'(n), W'(RC));
    repeat (4) @(negedge clock);

    check("host_writes", W'(hw_seen), W'(hw_exp));
    check("continue_pulses", W'(cont_seen), W'(cont_exp));
    check("rsp_all_seen", W'(exp_q.size()), '0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== exp_mem[i]) mism++;
    check("mem_image", W'(mism), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
